// File: rtl/decode_queue.sv
// Decode queue: DEPTH-entry instruction FIFO with register-file read for the head,
// a pending-write scoreboard for RAW/WAW stalls, and one registered output entry.
module decode_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int NREG  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [31:0]              f_instr,
  input  logic [XLEN-1:0]          f_pc,
  output logic [$clog2(NREG)-1:0]  ra1,
  output logic [$clog2(NREG)-1:0]  ra2,
  input  logic [XLEN-1:0]          rd1,
  input  logic [XLEN-1:0]          rd2,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [XLEN-1:0]          d_pc,
  output logic [31:0]              d_instr,
  output logic [XLEN-1:0]          d_rs1,
  output logic [XLEN-1:0]          d_rs2,
  output logic [$clog2(NREG)-1:0]  d_rd,
  output logic                     d_wen,
  input  logic                     wb_valid,
  input  logic [$clog2(NREG)-1:0]  wb_rd,
  input  logic                     flush
);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(NREG);

  logic [31:0]     r_mem_instr [DEPTH];
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PW:0]     r_count;
  logic [NREG-1:0] r_busy;

  logic            r_d_valid, r_d_wen;
  logic [XLEN-1:0] r_d_pc, r_d_rs1, r_d_rs2;
  logic [31:0]     r_d_instr;
  logic [RW-1:0]   r_d_rd;

  logic            w_push, w_adv, w_hs, w_head_valid, w_head_wen, w_stall;
  logic [31:0]     w_head_instr;
  logic [6:0]      w_head_op;
  logic [RW-1:0]   w_head_rd, w_head_rs1, w_head_rs2;
  logic [NREG-1:0] w_pend;

  assign f_ready      = (r_count != (PW+1)'(DEPTH)) && !flush;
  assign w_push       = f_valid && f_ready;
  assign w_head_valid = (r_count != '0);
  assign w_head_instr = r_mem_instr[r_rd_ptr];
  assign w_head_op    = w_head_instr[6:0];
  assign w_head_rd    = w_head_instr[7 +: RW];
  assign w_head_rs1   = w_head_instr[15 +: RW];
  assign w_head_rs2   = w_head_instr[20 +: RW];
  assign w_head_wen   = (w_head_op != 7'b0100011) && (w_head_op != 7'b1100011) && (w_head_rd != '0);
  assign ra1          = w_head_rs1;
  assign ra2          = w_head_rs2;

  // A register is pending if retired-but-not-written-back or held in the output stage.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    if (gi == 0) begin : g_x0
      assign w_pend[gi] = 1'b0;
    end else begin : g_xn
      assign w_pend[gi] = r_busy[gi] || (r_d_valid && r_d_wen && (r_d_rd == RW'(gi)));
    end
  end

  assign w_stall = w_pend[w_head_rs1] || w_pend[w_head_rs2] || (w_head_wen && w_pend[w_head_rd]);
  assign w_adv   = w_head_valid && !w_stall && (!r_d_valid || d_ready) && !flush;
  assign w_hs    = r_d_valid && d_ready && !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= f_instr;
      r_mem_pc[r_wr_ptr]    <= f_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_adv)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_adv})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set on handshake beats a same-cycle writeback clear of the same register.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    always_ff @(posedge clk) begin
      if (reset || gi == 0)
        r_busy[gi] <= 1'b0;
      else if (w_hs && r_d_wen && (r_d_rd == RW'(gi)))
        r_busy[gi] <= 1'b1;
      else if (wb_valid && (wb_rd == RW'(gi)))
        r_busy[gi] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_valid <= 1'b0;
      r_d_pc    <= '0;
      r_d_instr <= '0;
      r_d_rs1   <= '0;
      r_d_rs2   <= '0;
      r_d_rd    <= '0;
      r_d_wen   <= 1'b0;
    end else if (w_adv) begin
      r_d_valid <= 1'b1;
      r_d_pc    <= r_mem_pc[r_rd_ptr];
      r_d_instr <= w_head_instr;
      r_d_rs1   <= rd1;
      r_d_rs2   <= rd2;
      r_d_rd    <= w_head_rd;
      r_d_wen   <= w_head_wen;
    end else if (flush || (r_d_valid && d_ready)) begin
      r_d_valid <= 1'b0;
    end
  end

  assign d_valid = r_d_valid;
  assign d_pc    = r_d_pc;
  assign d_instr = r_d_instr;
  assign d_rs1   = r_d_rs1;
  assign d_rs2   = r_d_rs2;
  assign d_rd    = r_d_rd;
  assign d_wen   = r_d_wen;

endmodule

// File: tb/tb_decode_queue.sv
// Randomized bench for decode_queue against a queue-based reference model with a
// behavioural register file and scoreboard.
module tb_decode_queue;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset, f_valid, f_ready, d_valid, d_ready, d_wen, wb_valid, flush;
  logic [31:0]     f_instr, d_instr;
  logic [XLEN-1:0] f_pc, rd1, rd2, d_pc, d_rs1, d_rs2;
  logic [4:0]      ra1, ra2, d_rd, wb_rd;

  logic [XLEN-1:0] rf [32];
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NREG(32)) dut (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr),
    .f_pc(f_pc), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .d_valid(d_valid),
    .d_ready(d_ready), .d_pc(d_pc), .d_instr(d_instr), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rd(d_rd), .d_wen(d_wen), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ent_t;

  ent_t            mq[$];
  bit              m_ov, m_wen;
  logic [XLEN-1:0] m_pc, m_rs1, m_rs2;
  logic [31:0]     m_instr;
  logic [4:0]      m_rd;
  bit              mb [32];
  logic [XLEN-1:0] pc_ctr;
  bit              rf_wr_pend;
  logic [4:0]      rf_wr_reg;
  logic [XLEN-1:0] rf_wr_val;
  int              checks = 0;
  int              errors = 0;
  int              issued = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit wen_of(input logic [31:0] i);
    return (i[6:0] != 7'b0100011) && (i[6:0] != 7'b1100011) && (i[11:7] != 5'd0);
  endfunction

  function automatic bit pend(input logic [4:0] r);
    return (r != 5'd0) && (mb[r] || (m_ov && m_wen && m_rd == r));
  endfunction

  function automatic logic [31:0] gen_instr(input int mode);
    logic [6:0] ops [5];
    logic [6:0] op;
    ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011;
    if (mode == 0)
      return {12'd0, 5'd0, 3'd0, 5'($urandom_range(1, 31)), ops[0]};
    op = ops[$urandom_range(0, 4)];
    return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'($urandom_range(0, 7)), op};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ov = 0; m_wen = 0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_instr = '0; m_rd = '0;
    for (int i = 0; i < 32; i++) mb[i] = 0;
  endtask

  task automatic apply_rf_write();
    if (rf_wr_pend) rf[rf_wr_reg] = rf_wr_val;
    rf_wr_pend = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply_rf_write();
    reset = 1; f_valid = 0; d_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    f_instr = '0; f_pc = '0;
    @(negedge clk);
    reset = 0;
    model_reset();
    #1;
    chk("rst_d_valid", d_valid, 0);
    chk("rst_f_ready", f_ready, 1);
    chk("rst_d_pc", d_pc, 0);
    chk("rst_d_instr", d_instr, 0);
    chk("rst_d_rs1", d_rs1, 0);
    chk("rst_d_rs2", d_rs2, 0);
    chk("rst_d_rd", d_rd, 0);
    chk("rst_d_wen", d_wen, 0);
  endtask

  task automatic cycle(input int p_fv, input int p_dr, input int p_wb, input int p_fl, input int mode);
    bit fr, push, hv, stall, adv, hs;
    ent_t h;
    int busy_list[$];
    @(negedge clk);
    apply_rf_write();
    f_valid  = ($urandom_range(0, 99) < p_fv);
    f_instr  = gen_instr(mode);
    f_pc     = pc_ctr;
    d_ready  = ($urandom_range(0, 99) < p_dr);
    flush    = ($urandom_range(0, 99) < p_fl);
    wb_valid = ($urandom_range(0, 99) < p_wb);
    for (int i = 1; i < 32; i++) if (mb[i]) busy_list.push_back(i);
    if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
      wb_rd = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
    else
      wb_rd = 5'($urandom_range(0, 7));
    #1;
    fr = (mq.size() != DEPTH) && !flush;
    chk("f_ready", f_ready, fr);
    chk("d_valid", d_valid, m_ov);
    if (m_ov) begin
      chk("d_pc", d_pc, m_pc);
      chk("d_instr", d_instr, m_instr);
      chk("d_rs1", d_rs1, m_rs1);
      chk("d_rs2", d_rs2, m_rs2);
      chk("d_rd", d_rd, m_rd);
      chk("d_wen", d_wen, m_wen);
    end
    hv = (mq.size() > 0);
    if (hv) begin
      h = mq[0];
      chk("ra1", ra1, h.instr[19:15]);
      chk("ra2", ra2, h.instr[24:20]);
    end
    push  = f_valid && fr;
    stall = hv && (pend(h.instr[19:15]) || pend(h.instr[24:20]) ||
                   (wen_of(h.instr) && pend(h.instr[11:7])));
    adv   = hv && !stall && (!m_ov || d_ready) && !flush;
    hs    = m_ov && d_ready && !flush;
    if (wb_valid && wb_rd != 0) mb[wb_rd] = 0;
    if (hs && m_wen) mb[m_rd] = 1;
    if (adv) begin
      m_ov = 1; m_pc = h.pc; m_instr = h.instr;
      m_rs1 = rf[h.instr[19:15]]; m_rs2 = rf[h.instr[24:20]];
      m_rd = h.instr[11:7]; m_wen = wen_of(h.instr);
      issued++;
    end else if (flush || hs) begin
      m_ov = 0;
    end
    if (flush) mq.delete();
    else begin
      if (adv) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: pc_ctr, instr: f_instr});
        pc_ctr += 4;
      end
    end
    if (wb_valid && wb_rd != 0) begin
      rf_wr_pend = 1; rf_wr_reg = wb_rd; rf_wr_val = {$urandom, $urandom};
    end
  endtask

  initial begin
    reset = 1; f_valid = 0; d_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    f_instr = '0; f_pc = '0; pc_ctr = 64'h1000; rf_wr_pend = 0;
    rf_wr_reg = '0; rf_wr_val = '0;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : {$urandom, $urandom};
    do_reset();
    for (int n = 0; n < 40; n++)  cycle(100, 100, 40, 0, 0);
    for (int n = 0; n < 40; n++)  cycle(100, 10, 20, 0, 1);
    for (int n = 0; n < 800; n++) cycle(70, 70, 30, 3, 1);
    for (int n = 0; n < 5; n++)   cycle(100, 0, 0, 0, 1);
    do_reset();
    for (int n = 0; n < 400; n++) cycle(60, 60, 35, 5, 1);
    chk("progress", (issued > 200), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
